// File: rtl/im_loader.sv
// Serial instruction-memory loader: 16-bit word-count header, then big-endian 32-bit words
// written at BASE+4k. Define IM_LOADER_CHECKSUM_EN for a trailing modulo-256 checksum byte.
module im_loader #(
  parameter int          SIZE = 4096,
  parameter logic [31:0] BASE = 32'h3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
`ifdef IM_LOADER_CHECKSUM_EN
    , CSUM = 3'd6
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_widx;
  logic [1:0]  r_bcnt;
  logic [23:0] r_asm;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_error;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_xfer;
  logic [15:0] w_n;
  logic        w_bad_n;
  logic        w_last;

`ifdef IM_LOADER_CHECKSUM_EN
  assign byte_ready = (r_state == HDR_HI) || (r_state == HDR_LO) ||
                      (r_state == DATA)   || (r_state == CSUM);
`else
  assign byte_ready = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
`endif
  // busy stretches over the write cycle that follows the final data byte
  assign busy    = byte_ready | r_we;
  assign w_xfer  = byte_valid & byte_ready;
  assign w_n     = {r_n[15:8], byte_data};
  assign w_bad_n = (w_n == 16'd0) || ({16'd0, w_n} > 32'(SIZE));
  assign w_last  = (r_widx == r_n - 16'd1);

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign done  = r_done;
  assign error = r_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_widx  <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
`ifdef IM_LOADER_CHECKSUM_EN
`else
          // no checksum: done rises the cycle after the final write strobe
          if (r_state == DONE && r_we) r_done <= 1'b1;
`endif
          if (start && !busy) begin
            r_state <= HDR_HI;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_widx  <= '0;
            r_bcnt  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        HDR_HI: if (w_xfer) begin
          r_n[15:8] <= byte_data;
          r_state   <= HDR_LO;
        end
        HDR_LO: if (w_xfer) begin
          r_n <= w_n;
          if (w_bad_n) begin
            r_state <= ERR;
            r_error <= 1'b1;
          end else begin
            r_state <= DATA;
          end
        end
        DATA: if (w_xfer) begin
          r_bcnt <= r_bcnt + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          r_sum  <= r_sum + byte_data;
`endif
          if (r_bcnt == 2'd3) begin
            r_we    <= 1'b1;
            r_wdata <= {r_asm, byte_data};
            r_waddr <= BASE + {14'd0, r_widx, 2'b00};
            r_widx  <= r_widx + 16'd1;
            if (w_last) begin
`ifdef IM_LOADER_CHECKSUM_EN
              r_state <= CSUM;
`else
              r_state <= DONE;
`endif
            end
          end else begin
            r_asm <= {r_asm[15:0], byte_data};
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CSUM: if (w_xfer) begin
          if (byte_data == r_sum) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ERR;
            r_error <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter SIZE, default 4096, meaning the instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h3000, meaning the byte address of instruction word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset; the block resets when reset==0 at a rising clk edge.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a load session.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-007 SHALL have port byte_data, input, 8 bits: serial load stream byte.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader accepts the byte this cycle.
REQ-009 SHALL have port we, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port waddr, output, 32 bits: byte address of the word being written.
REQ-011 SHALL have port wdata, output, 32 bits: instruction word being written.
REQ-012 SHALL have port busy, output, 1 bit: a session is in progress; the CPU is held off while it is high.
REQ-013 SHALL have port done, output, 1 bit: the last session completed successfully.
REQ-014 SHALL have port error, output, 1 bit: the last session was aborted.

Function
REQ-015 SHALL implement states IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE and ERR; CSUM is present only with the configuration macro defined.
REQ-016 A byte SHALL transfer when byte_valid and byte_ready are both 1 on a rising clk edge.
REQ-017 byte_ready SHALL be 1 exactly in HDR_HI, HDR_LO, DATA and CSUM.
REQ-018 IDLE, DONE or ERR with start==1 SHALL go to HDR_HI and clear done, error, the word index and the byte counter.
REQ-019 start SHALL be ignored while busy is 1.
REQ-020 HDR_HI and HDR_LO SHALL capture a 16-bit word count N, MSB first.
REQ-021 After HDR_LO: N==0 or N>SIZE SHALL go to ERR; otherwise the block SHALL go to DATA.
REQ-022 DATA SHALL assemble each group of 4 bytes into one word, first byte to bits [31:24].
REQ-023 The cycle after the 4th byte of word k is accepted, the outputs SHALL be: we=1 for exactly one cycle, waddr=BASE+4*k (32-bit wrap), and wdata=the assembled word.
REQ-024 DATA SHALL continue accepting bytes during the write cycle; writes never stall the stream.
REQ-025 After the 4th byte of word N-1, the block SHALL go to DONE, or to CSUM if the macro is defined.
REQ-026 busy SHALL be 1 in HDR_HI, HDR_LO, DATA and CSUM, and through the final write cycle.
REQ-027 done SHALL be asserted on the cycle after the final we pulse and held until the next start or reset.
REQ-028 error SHALL be asserted on entry to ERR and held until the next start or reset.
REQ-029 In DONE and ERR, the block SHALL ignore byte_valid.

Reset
REQ-030 reset==0 SHALL force IDLE, byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, and clear all counters and the checksum, regardless of the current state, including mid-word.
REQ-031 When reset aborts a session, the block SHALL not issue a partial-word write.

Configuration
REQ-032 With macro IM_LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all DATA bytes.
REQ-033 With IM_LOADER_CHECKSUM_EN defined, CSUM SHALL accept one byte; if it equals the sum the block SHALL go to DONE, otherwise to ERR.
REQ-034 With IM_LOADER_CHECKSUM_EN defined, words already written before a checksum mismatch SHALL remain written.
REQ-035 Without IM_LOADER_CHECKSUM_EN, the block SHALL have no CSUM state and no sum register, and the trailing byte SHALL not be consumed.

Verification
REQ-036 Scenario: start, then bytes 00 01 24 08 00 00, byte_valid held high -> one we pulse with waddr=32'h3000 and wdata=32'h24080000; done=1 on the next cycle; busy=0.
REQ-037 Scenario: header 00 03 followed by 12 bytes with byte_valid toggled every cycle -> three we pulses at 3000, 3004 and 3008; byte order preserved.
REQ-038 Scenario: header 00 00, and separately header 10 01 with SIZE=4096 -> ERR, error=1, no we pulse.
REQ-039 Scenario: reset driven low after 2 data bytes of word 1, then high -> all outputs at reset values, no we pulse; a new start reloads correctly.
REQ-040 Scenario: start pulsed mid-DATA -> no effect; the session completes normally.
REQ-041 Scenario (IM_LOADER_CHECKSUM_EN): one word 01 02 03 04 followed by checksum 0A -> done=1; followed by checksum 0B -> error=1, and the word at 3000 is still written.
